// File: rtl/audio_pkg.sv
// Shared constants and FSM state type for the audio burst reader.
package audio_pkg;

  localparam int unsigned AUDIO_ADDR_W     = 19;
  localparam int unsigned AUDIO_DATA_W     = 32;
  localparam int unsigned AUDIO_BURST_MAX  = 8;
  localparam int unsigned AUDIO_FIFO_DEPTH = 16;
  localparam int unsigned AUDIO_BCNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FLUSH
  } state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Show-ahead sample FIFO with registered head word and free-slot count.
// Ports: clk/rst_n, clr (synchronous flush), wr_en/wr_data (push),
//        rd_en (pop head), rd_data/valid (registered head), free (empty slots).
module audio_sample_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_wr;
  logic              do_rd;
  logic [PTR_W-1:0]  rd_ptr_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [DATA_W-1:0] head_n;

  // A pop frees a slot, so a push into a full FIFO is accepted alongside it.
  assign do_rd = rd_en && (cnt != '0);
  assign do_wr = wr_en && ((cnt != CNT_W'(DEPTH)) || do_rd);
  assign free  = CNT_W'(DEPTH) - cnt;

  // Next head: the incoming word when the FIFO would otherwise be empty.
  always_comb begin
    rd_ptr_n = rd_ptr + PTR_W'(do_rd);
    cnt_n    = cnt + CNT_W'(do_wr) - CNT_W'(do_rd);
    head_n   = '0;
    if (cnt_n != '0) begin
      head_n = ((cnt - CNT_W'(do_rd)) == '0) ? wr_data : mem[rd_ptr_n];
    end
  end

  // Storage array, no reset needed: the head register masks stale contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      rd_data <= '0;
      valid   <= 1'b0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      rd_data <= '0;
      valid   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr  <= rd_ptr_n;
      cnt     <= cnt_n;
      rd_data <= head_n;
      valid   <= (cnt_n != '0);
    end
  end

endmodule

// File: rtl/audio_burst_reader.sv
// Avalon-MM burst read master streaming a clip of audio words into a sample FIFO.
// Ports: clk_clk/reset_reset_n; start/abort/loop_en/start_addr/length control,
//        busy/done status; avm_* pipelined burst read master; sample_* stream out.
module audio_burst_reader
  import audio_pkg::*;
#(
  parameter int unsigned ADDR_W     = AUDIO_ADDR_W,
  parameter int unsigned DATA_W     = AUDIO_DATA_W,
  parameter int unsigned BURST_MAX  = AUDIO_BURST_MAX,
  parameter int unsigned FIFO_DEPTH = AUDIO_FIFO_DEPTH
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    loop_en,
  input  logic [ADDR_W-1:0]       start_addr,
  input  logic [ADDR_W-1:0]       length,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       avm_address,
  output logic                    avm_read,
  output logic [AUDIO_BCNT_W-1:0] avm_burstcount,
  input  logic                    avm_waitrequest,
  input  logic [DATA_W-1:0]       avm_readdata,
  input  logic                    avm_readdatavalid,
  output logic [DATA_W-1:0]       sample_data,
  output logic                    sample_valid,
  input  logic                    sample_ready
);

  localparam int unsigned FREE_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BCNT_W = AUDIO_BCNT_W;

  state_t             state;
  logic [ADDR_W-1:0]  cur_addr;
  logic [ADDR_W-1:0]  remaining;
  logic [ADDR_W-1:0]  base_addr;
  logic [ADDR_W-1:0]  base_len;
  logic [BCNT_W-1:0]  beats_left;
  logic               loop_r;
  logic               aborting;

  logic [BCNT_W-1:0]  burst_n;
  logic [FREE_W-1:0]  fifo_free;
  logic               fifo_empty;
  logic               fifo_wr;
  logic               fifo_rd;
  logic               fifo_clr;
  logic               accept;
  logic               last_beat;

  function automatic logic [BCNT_W-1:0] burst_size(input logic [ADDR_W-1:0] words);
    return (words >= ADDR_W'(BURST_MAX)) ? BCNT_W'(BURST_MAX) : words[BCNT_W-1:0];
  endfunction

  assign burst_n    = burst_size(remaining);
  assign fifo_empty = (fifo_free == FREE_W'(FIFO_DEPTH));
  assign accept     = (state == ST_ISSUE) && avm_read && !avm_waitrequest;
  assign last_beat  = (state == ST_DRAIN) && avm_readdatavalid && (beats_left == BCNT_W'(1));
  // Beats of an aborted burst are still counted but never stored.
  assign fifo_wr    = (state == ST_DRAIN) && avm_readdatavalid && !aborting && !abort;
  assign fifo_rd    = sample_valid && sample_ready;
  assign fifo_clr   = ((state == ST_ISSUE) && abort && !accept) ||
                      ((state == ST_FLUSH) && abort) ||
                      (last_beat && (aborting || abort));

  audio_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .clr     (fifo_clr),
    .wr_en   (fifo_wr),
    .wr_data (avm_readdata),
    .rd_en   (fifo_rd),
    .rd_data (sample_data),
    .valid   (sample_valid),
    .free    (fifo_free)
  );

  // Clip sequencing: burst issue, beat counting, looping, flush and abort.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state          <= ST_IDLE;
      cur_addr       <= '0;
      remaining      <= '0;
      base_addr      <= '0;
      base_len       <= '0;
      beats_left     <= '0;
      loop_r         <= 1'b0;
      aborting       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      avm_read       <= 1'b0;
      avm_address    <= '0;
      avm_burstcount <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              cur_addr  <= start_addr;
              remaining <= length;
              base_addr <= start_addr;
              base_len  <= length;
              loop_r    <= loop_en;
              aborting  <= 1'b0;
              busy      <= 1'b1;
              state     <= ST_ISSUE;
              // First request goes out directly so start->read is one cycle.
              if (fifo_free >= FREE_W'(burst_size(length))) begin
                avm_read       <= 1'b1;
                avm_address    <= start_addr;
                avm_burstcount <= burst_size(length);
              end
            end
          end
        end
        ST_ISSUE: begin
          if (accept) begin
            avm_read   <= 1'b0;
            cur_addr   <= cur_addr + ADDR_W'(avm_burstcount);
            remaining  <= remaining - ADDR_W'(avm_burstcount);
            beats_left <= avm_burstcount;
            aborting   <= abort;
            state      <= ST_DRAIN;
          end else if (abort) begin
            avm_read <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else if (!avm_read && (fifo_free >= FREE_W'(burst_n))) begin
            avm_read       <= 1'b1;
            avm_address    <= cur_addr;
            avm_burstcount <= burst_n;
          end
        end
        ST_DRAIN: begin
          if (abort) aborting <= 1'b1;
          if (avm_readdatavalid) begin
            beats_left <= beats_left - BCNT_W'(1);
            if (beats_left == BCNT_W'(1)) begin
              if (aborting || abort) begin
                aborting <= 1'b0;
                done     <= 1'b1;
                busy     <= 1'b0;
                state    <= ST_IDLE;
              end else if (remaining != '0) begin
                state <= ST_ISSUE;
              end else if (loop_r) begin
                cur_addr  <= base_addr;
                remaining <= base_len;
                state     <= ST_ISSUE;
              end else begin
                state <= ST_FLUSH;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (abort || fifo_empty) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_burst_reader.sv
// Directed bench for audio_burst_reader with an Avalon burst slave model.
module tb_audio_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, loop_en;
  logic [18:0] start_addr, length;
  logic        busy, done;
  logic [18:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_burstcount;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave state and stall control
  int          stall_cfg;
  int          stall_left;
  logic [18:0] s_addr;
  logic [3:0]  s_cnt;

  // Monitor logs
  logic [18:0] b_addr[$];
  logic [3:0]  b_cnt[$];
  logic [31:0] got[$];
  int          done_cnt = 0;
  int          rdv_total = 0;
  int          wait_seen = 0;
  int          stab_err = 0;
  logic        done_sv = 1'b0;
  logic        hold_prev = 1'b0;
  logic [18:0] prev_a = '0;
  logic [3:0]  prev_c = '0;

  always #5 clk = ~clk;

  audio_burst_reader dut (
    .clk_clk           (clk),
    .reset_reset_n     (rst_n),
    .start             (start),
    .abort             (abort),
    .loop_en           (loop_en),
    .start_addr        (start_addr),
    .length            (length),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .sample_data       (sample_data),
    .sample_valid      (sample_valid),
    .sample_ready      (sample_ready)
  );

  function automatic logic [31:0] word_at(input logic [18:0] a);
    return 32'hCAFE0000 ^ 32'(a);
  endfunction

  assign avm_waitrequest = (stall_left != 0);

  // Slave: stalls stall_cfg cycles per request, then returns one beat per cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_left        <= 0;
      s_addr            <= '0;
      s_cnt             <= '0;
      avm_readdatavalid <= 1'b0;
      avm_readdata      <= '0;
    end else begin
      if (!avm_read) stall_left <= stall_cfg;
      else if (stall_left != 0) stall_left <= stall_left - 1;
      if (avm_read && !avm_waitrequest) begin
        s_addr            <= avm_address;
        s_cnt             <= avm_burstcount;
        avm_readdatavalid <= 1'b0;
      end else if (s_cnt != 0) begin
        avm_readdatavalid <= 1'b1;
        avm_readdata      <= word_at(s_addr);
        s_addr            <= s_addr + 19'd1;
        s_cnt             <= s_cnt - 4'd1;
      end else begin
        avm_readdatavalid <= 1'b0;
      end
    end
  end

  // Bus and stream monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (avm_read && !avm_waitrequest) begin
        b_addr.push_back(avm_address);
        b_cnt.push_back(avm_burstcount);
      end
      if (avm_read && avm_waitrequest) wait_seen <= wait_seen + 1;
      if (hold_prev && !(avm_read && avm_address == prev_a && avm_burstcount == prev_c))
        stab_err <= stab_err + 1;
      hold_prev <= avm_read && avm_waitrequest;
      prev_a    <= avm_address;
      prev_c    <= avm_burstcount;
      if (sample_valid && sample_ready) got.push_back(sample_data);
      if (avm_readdatavalid) rdv_total <= rdv_total + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_sv  <= sample_valid;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [18:0] a, input logic [18:0] len, input logic lp);
    start_addr = a;
    length     = len;
    loop_en    = lp;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int ds, input int bound, input string tag);
    int i;
    i = 0;
    while (done_cnt == ds && i < bound) begin
      tick();
      i++;
    end
    if (done_cnt == ds) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_burst(input string tag, input int idx, input logic [18:0] a, input logic [3:0] c);
    if (idx >= b_addr.size()) begin
      check({tag, "_missing"}, b_addr.size(), idx + 1);
    end else begin
      check({tag, "_addr"}, b_addr[idx], a);
      check({tag, "_cnt"}, b_cnt[idx], c);
    end
  endtask

  task automatic check_samples(input string tag, input int gs, input logic [18:0] base,
                               input int n, input int period);
    if (got.size() - gs < n) begin
      check({tag, "_count"}, got.size() - gs, n);
    end else begin
      for (int i = 0; i < n; i++)
        check(tag, got[gs + i], word_at(base + 19'(i % period)));
    end
  endtask

  initial begin
    int bs, gs, ds, rs, ws, maxb, cur, i;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
    start_addr = '0; length = '0; sample_ready = 1'b1; stall_cfg = 0;
    repeat (3) @(negedge clk);
    check("rst_read", avm_read, 0);
    check("rst_addr", avm_address, 0);
    check("rst_bcnt", avm_burstcount, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_data", sample_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // Plain 20-word clip
    bs = b_addr.size(); gs = got.size(); ds = done_cnt;
    pulse_start(19'h00100, 19'd20, 1'b0);
    @(negedge clk);
    check("t1_latency_read", avm_read, 1);
    check("t1_first_addr", avm_address, 19'h00100);
    check("t1_first_bcnt", avm_burstcount, 8);
    check("t1_busy", busy, 1);
    wait_done(ds, 500, "t1");
    check("t1_busy_after", busy, 0);
    check("t1_nbursts", b_addr.size() - bs, 3);
    check_burst("t1_b0", bs, 19'h00100, 4'd8);
    check_burst("t1_b1", bs + 1, 19'h00108, 4'd8);
    check_burst("t1_b2", bs + 2, 19'h00110, 4'd4);
    check_samples("t1_sample", gs, 19'h00100, 20, 20);
    repeat (3) tick();
    check("t1_done_once", done_cnt - ds, 1);

    // Slave stalls 5 cycles per request
    stall_cfg = 5;
    bs = b_addr.size(); gs = got.size(); ds = done_cnt; ws = wait_seen;
    pulse_start(19'h02000, 19'd16, 1'b0);
    wait_done(ds, 600, "t2");
    check("t2_nbursts", b_addr.size() - bs, 2);
    check_burst("t2_b0", bs, 19'h02000, 4'd8);
    check_burst("t2_b1", bs + 1, 19'h02008, 4'd8);
    check("t2_wait_cycles", wait_seen - ws, 10);
    check("t2_stable", stab_err, 0);
    check_samples("t2_sample", gs, 19'h02000, 16, 16);
    stall_cfg = 0;
    tick();

    // Backpressure: FIFO fills and issue stalls on free slots
    sample_ready = 1'b0;
    bs = b_addr.size(); gs = got.size(); ds = done_cnt; rs = rdv_total; maxb = 0;
    pulse_start(19'h01000, 19'd40, 1'b0);
    for (int k = 0; k < 80; k++) begin
      tick();
      cur = (rdv_total - rs) - (got.size() - gs);
      if (cur > maxb) maxb = cur;
    end
    check("t3_nbursts_stalled", b_addr.size() - bs, 2);
    check("t3_max_buffered", maxb, 16);
    check("t3_valid_held", sample_valid, 1);
    sample_ready = 1'b1;
    wait_done(ds, 2000, "t3");
    check("t3_nbursts", b_addr.size() - bs, 5);
    check_burst("t3_b2", bs + 2, 19'h01010, 4'd8);
    check_burst("t3_b4", bs + 4, 19'h01020, 4'd8);
    check_samples("t3_sample", gs, 19'h01000, 40, 40);

    // Address wrap at top of the storage
    bs = b_addr.size(); gs = got.size(); ds = done_cnt;
    pulse_start(19'h7FFFC, 19'd8, 1'b0);
    wait_done(ds, 500, "t4");
    check("t4_nbursts", b_addr.size() - bs, 1);
    check_burst("t4_b0", bs, 19'h7FFFC, 4'd8);
    check_samples("t4_sample", gs, 19'h7FFFC, 8, 8);

    // Looping clip, then abort mid-DRAIN
    gs = got.size(); ds = done_cnt;
    pulse_start(19'h00200, 19'd3, 1'b1);
    i = 0;
    while (got.size() - gs < 9 && i < 500) begin tick(); i++; end
    check_samples("t5_loop", gs, 19'h00200, 9, 3);
    check("t5_no_done", done_cnt - ds, 0);
    check("t5_busy", busy, 1);
    i = 0;
    do begin @(negedge clk); i++; end while (!(avm_read && !avm_waitrequest) && i < 200);
    check("t5_accept_seen", avm_read && !avm_waitrequest, 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(ds, 200, "t5");
    check("t5_abort_done", done_cnt - ds, 1);
    check("t5_fifo_empty_at_done", done_sv, 0);
    check("t5_beats_drained", s_cnt, 0);
    check("t5_busy_after", busy, 0);
    repeat (3) tick();
    check("t5_valid_after", sample_valid, 0);
    check("t5_done_single", done_cnt - ds, 1);

    // Empty clip
    bs = b_addr.size(); ds = done_cnt;
    pulse_start(19'h00300, 19'd0, 1'b0);
    @(negedge clk);
    check("t6_done", done, 1);
    check("t6_busy", busy, 0);
    check("t6_read", avm_read, 0);
    tick();
    check("t6_done_pulse", done, 0);
    repeat (4) tick();
    check("t6_no_burst", b_addr.size() - bs, 0);

    // Start while busy is ignored
    bs = b_addr.size(); gs = got.size(); ds = done_cnt;
    pulse_start(19'h00300, 19'd8, 1'b0);
    repeat (2) tick();
    pulse_start(19'h00400, 19'd4, 1'b0);
    wait_done(ds, 500, "t7");
    repeat (4) tick();
    check("t7_nbursts", b_addr.size() - bs, 1);
    check_burst("t7_b0", bs, 19'h00300, 4'd8);
    check("t7_nsamples", got.size() - gs, 8);
    check_samples("t7_sample", gs, 19'h00300, 8, 8);
    check("t7_done_once", done_cnt - ds, 1);

    // Reset in the middle of a burst
    rs = rdv_total;
    pulse_start(19'h00500, 19'd16, 1'b0);
    i = 0;
    while (rdv_total - rs < 3 && i < 200) begin tick(); i++; end
    rst_n = 1'b0;
    #1;
    check("t8_rst_read", avm_read, 0);
    check("t8_rst_busy", busy, 0);
    check("t8_rst_valid", sample_valid, 0);
    check("t8_rst_addr", avm_address, 0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("t8_idle_busy", busy, 0);
    check("t8_idle_valid", sample_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/audio_burst_reader.md
# audio_burst_reader

Avalon-MM burst read master that streams audio sample words out of the on-chip audio storage into the playback path. Given a start word address and a length, it issues read bursts of up to 8 words and buffers the returned words in a local FIFO. It presents them as a valid/ready sample stream to the audio output logic, optionally looping the clip forever. It is the initiator side of the storage's pipelined read port.

## Interface
Parameters:
- ADDR_W, 19, word-address width of the storage port
- DATA_W, 32, sample word width
- BURST_MAX, 8, largest burst issued (must be ≤ 15)
- FIFO_DEPTH, 16, sample FIFO depth (power of two, ≥ 2·BURST_MAX)

Ports (one clock `clk_clk`; reset `reset_reset_n` is asynchronous, active-low):
- clk_clk  in  1  system clock
- reset_reset_n  in  1  async active-low reset
- start  in  1  one-cycle pulse; begin a clip (ignored while busy)
- abort  in  1  one-cycle pulse; stop the clip
- loop_en  in  1  sampled at start; replay the clip when it ends
- start_addr  in  ADDR_W  first word address
- length  in  ADDR_W  clip length in words; 0 means empty clip
- busy  out  1  clip in progress
- done  out  1  one-cycle pulse at clip end or abort completion
- avm_address  out  ADDR_W  burst word address
- avm_read  out  1  read request
- avm_burstcount  out  4  burst length
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_W  returned word
- avm_readdatavalid  in  1  returned word valid
- sample_data  out  DATA_W  head of FIFO
- sample_valid  out  1  FIFO non-empty
- sample_ready  in  1  consumer takes a sample

## Operation
- States: IDLE, ISSUE, DRAIN, FLUSH.
- IDLE: on `start` (without `abort`), latch start_addr, length, and loop_en into cur_addr, remaining, and loop_r. Set busy. Go to ISSUE; if length = 0, pulse done and stay IDLE.
- ISSUE: burst size n = min(BURST_MAX, remaining). Wait until FIFO free slots ≥ n. Then drive avm_read=1, avm_address=cur_addr, avm_burstcount=n, and hold all three stable while avm_waitrequest=1.
- On acceptance (read ∧ ¬waitrequest): cur_addr += n (mod 2^ADDR_W, wraps silently), remaining −= n, beats_left = n. Go to DRAIN.
- DRAIN: each avm_readdatavalid writes avm_readdata into the FIFO and decrements beats_left. Only one burst is outstanding at a time.
- When beats_left reaches 0:
  - if remaining > 0, go to ISSUE;
  - else if loop_r, reload cur_addr and remaining from the latched values and go to ISSUE;
  - else go to FLUSH.
- FLUSH: wait for the FIFO to empty, then pulse done, clear busy, and go to IDLE.
- Abort in ISSUE before acceptance: drop avm_read, clear the FIFO, pulse done, go to IDLE.
- Abort in DRAIN: stop issuing. Discard the remaining beats of the burst (the slave cannot cancel them), then clear the FIFO, pulse done, go to IDLE.
- Abort in FLUSH: clear the FIFO at once, pulse done, go to IDLE.
- A `start` that arrives while busy is ignored.
- Simultaneous FIFO write and read is legal, including when the FIFO is full (read frees the slot) or empty (write bypasses nothing; the data appears the next cycle).

## Timing
- Reset values:
  - avm_read=0, avm_address=0, avm_burstcount=0
  - busy=0, done=0
  - sample_valid=0, sample_data=0
  - FIFO empty, state IDLE
- All outputs are registered.
- start → avm_read high: 1 cycle, provided the FIFO has room.
- avm_read drops the cycle after acceptance.
- readdatavalid in cycle t → sample_valid/sample_data updated at t+1 (show-ahead FIFO).
- A sample is consumed on a cycle where sample_valid ∧ sample_ready.
- done is high for exactly 1 cycle; busy falls in the same cycle.
- Reset asserted mid-burst returns to the reset values immediately. Any beats the slave returns after reset release while in IDLE are ignored.

## Structure
- Shared package `audio_pkg`: ADDR_W/DATA_W/BURST_MAX constants and the state enum.
- Sub-module `audio_sample_fifo`: synchronous show-ahead FIFO with a free-slot count output.
- The top level holds the FSM, address and length counters, and burst sizing.

## Test plan
- start_addr=0x00100, length=20, no stall, sample_ready=1 → bursts issued (0x00100,8), (0x00108,8), (0x00110,4); 20 samples in order; done once; busy low afterwards.
- waitrequest held high 5 cycles → address/burstcount/read stable throughout; exactly one acceptance per burst.
- sample_ready=0, length=40 → at most 16 words buffered; no burst issued while free slots < n; 40 samples delivered after ready resumes.
- start_addr=0x7FFFC, length=8 → bursts at 0x7FFFC (n=8) then none; cur_addr wraps to 0x00004; all 8 words returned.
- loop_en=1, length=3 → samples repeat 0,1,2,0,1,2…; done never pulses. Abort mid-DRAIN → remaining beats discarded, FIFO empty, single done pulse.
- length=0 start → done pulse after 1 cycle, no avm_read. Start while busy → ignored.
